// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit.
package branch_resolve_unit_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bru_state_e;

    localparam logic [6:0]  BRANCH_OPCODE = 7'b1100011;
    localparam int unsigned INSN_SIZE     = 4;
    localparam int unsigned BRU_XLEN      = 32;

    typedef struct packed {
        logic                taken;
        logic [BRU_XLEN-1:0] pc;
    } bru_entry_t;

endpackage

// File: rtl/branch_resolve_unit_track_fifo.sv
// bru_track_fifo: in-order prediction tracking FIFO with wrap-bit pointers
// and a write-pointer rewind used to squash younger entries.
module bru_track_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             rewind,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_inc;

    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty      = (wr_ptr == rd_ptr);
    assign pop_data   = mem[rd_ptr[AW-1:0]];

    // rewind accompanies the pop of the mispredicted entry, so wr_ptr lands on the new rd_ptr
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr_inc;
            if (rewind)
                wr_ptr <= rd_ptr_inc;
            else if (push)
                wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rewind)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: tracks predictions, checks them at execute, trains the
// predictor and drives flush/redirect. Optional counters: BRU_PERF_CNT_EN.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned XLEN      = BRU_XLEN,
    parameter int unsigned FLUSH_LEN = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pred_valid,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_pc,
    output logic            stall_o,
    input  logic            ex_valid,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    output logic            flush_o,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            train_valid,
    output logic            train_truth,
    output logic            order_err
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    bru_state_e state, state_n;
    logic [3:0] flush_cnt, flush_cnt_n;
    bru_entry_t wr_entry, rd_entry;
    logic       full, empty;
    logic       in_run, pop_ok, push_ok, mispredict, order_set;

    assign wr_entry = '{taken: pred_taken, pc: pred_pc};

    bru_track_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(bru_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ok),
        .push_data (wr_entry),
        .pop       (pop_ok),
        .rewind    (mispredict),
        .pop_data  (rd_entry),
        .full      (full),
        .empty     (empty)
    );

    assign stall_o = full;
    assign flush_o = (state == FLUSH);

    always_comb begin
        in_run      = (state == RUN);
        pop_ok      = in_run && ex_valid && !empty;
        mispredict  = pop_ok && (rd_entry.taken != ex_taken);
        push_ok     = in_run && pred_valid && (!full || pop_ok) && !mispredict;
        order_set   = in_run && ex_valid && (empty || (rd_entry.pc != ex_pc));
        state_n     = state;
        flush_cnt_n = flush_cnt;
        case (state)
            RUN: begin
                if (mispredict) begin
                    state_n     = FLUSH;
                    flush_cnt_n = 4'(FLUSH_LEN - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt == '0)
                    state_n = RUN;
                else
                    flush_cnt_n = flush_cnt - 1'b1;
            end
            default: begin
                state_n     = RUN;
                flush_cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            flush_cnt      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            train_valid    <= 1'b0;
            train_truth    <= 1'b0;
            order_err      <= 1'b0;
        end else begin
            state          <= state_n;
            flush_cnt      <= flush_cnt_n;
            redirect_valid <= mispredict;
            train_valid    <= pop_ok;
            if (pop_ok)
                train_truth <= ex_taken;
            if (mispredict)
                redirect_pc <= ex_taken ? ex_target : ex_pc + XLEN'(INSN_SIZE);
            if (order_set)
                order_err <= 1'b1;
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (pop_ok && perf_branches != '1)
                perf_branches <= perf_branches + 1'b1;
            if (mispredict && perf_mispredicts != '1)
                perf_mispredicts <= perf_mispredicts + 1'b1;
        end
    end
`endif

endmodule
